// File: rtl/fconv_pkg.sv
// Shared types and constants for the int->float request scheduler.
package fconv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int unsigned FCONV_DW32 = 32;
    localparam int unsigned FCONV_DW64 = 64;

    // Ceiling log2, minimum result 1 so a tag always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'(1) << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/fconv_rr_arb.sv
// Combinational round-robin arbiter: first valid requester scanning upward from ptr_i, wrapping.
module fconv_rr_arb
    import fconv_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]    ptr_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [ID_W-1:0]    idx_o
);
    always_comb begin
        int  j;
        logic found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        j       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = (int'(ptr_i) + k) % NUM_REQ;
            if (en_i && !found && valid_i[j]) begin
                found      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = ID_W'(j);
            end
        end
    end

endmodule

// File: rtl/int2float.sv
// Combinational signed-integer to IEEE-754 converters (round to nearest, ties to even).
// int2float32 and int2float64 are thin wrappers around one shared core.
module int2float_core #(
    parameter int unsigned IW = 32,
    parameter int unsigned EW = 8,
    parameter int unsigned MW = 23
) (
    input  logic [IW-1:0] op_i,
    output logic [IW-1:0] res_o
);
    localparam int unsigned BIAS = (32'(1) << (EW - 1)) - 1;
    localparam int unsigned PW   = $clog2(IW);
    localparam int unsigned RW   = IW - 1 - MW;

    logic          sign;
    logic [IW-1:0] mag;
    logic [PW-1:0] lead;
    logic [IW-1:0] norm;
    logic [MW-1:0] mant;
    logic          guard;
    logic          sticky;
    logic          rnd;
    logic [MW:0]   mant_r;
    logic [EW-1:0] expo;

    always_comb begin
        sign = op_i[IW-1];
        mag  = sign ? (~op_i + IW'(1)) : op_i;
        lead = '0;
        for (int i = 0; i < IW; i++) begin
            if (mag[i]) lead = PW'(i);
        end
        // Leading one lands in the MSB; the bits below it form mantissa, guard and sticky.
        norm   = mag << (PW'(IW - 1) - lead);
        mant   = norm[IW-2 -: MW];
        guard  = norm[RW-1];
        sticky = |norm[RW-2:0];
        rnd    = guard & (sticky | mant[0]);
        mant_r = {1'b0, mant} + (MW+1)'(rnd);
        expo   = EW'(BIAS) + EW'(lead) + EW'(mant_r[MW]);
        res_o  = norm[IW-1] ? {sign, expo, mant_r[MW-1:0]} : '0;
    end

endmodule

module int2float32 (
    input  logic [31:0] op_i,
    output logic [31:0] res_o
);
    int2float_core #(.IW(32), .EW(8), .MW(23)) u_core (.op_i(op_i), .res_o(res_o));
endmodule

module int2float64 (
    input  logic [63:0] op_i,
    output logic [63:0] res_o
);
    int2float_core #(.IW(64), .EW(11), .MW(52)) u_core (.op_i(op_i), .res_o(res_o));
endmodule

// File: rtl/fconv_req_sched.sv
// Shares one int->float converter among NUM_REQ requesters with round-robin grant.
// Define FCONV_SCHED_PERF_EN to add perf_conv_cnt / perf_stall_cnt outputs.
module fconv_req_sched
    import fconv_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ID_W    = clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic [DATA_W-1:0]         res_data,
    output logic [ID_W-1:0]           res_id,
    output logic                      busy
`ifdef FCONV_SCHED_PERF_EN
    ,
    output logic [31:0]               perf_conv_cnt,
    output logic [31:0]               perf_stall_cnt
`endif
);

    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
        $error("fconv_req_sched: NUM_REQ must be 2..8");
    end
    if (ID_W != clog2(NUM_REQ)) begin : g_bad_id_w
        $error("fconv_req_sched: ID_W must equal clog2(NUM_REQ)");
    end

    state_e              state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [DATA_W-1:0]   op_q, op_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [DATA_W-1:0]   res_data_q, res_data_d;
    logic [ID_W-1:0]     res_id_q, res_id_d;
    logic                res_valid_q, res_valid_d;

    logic                arb_en;
    logic [NUM_REQ-1:0]  arb_grant;
    logic [ID_W-1:0]     arb_idx;
    logic [ID_W-1:0]     ptr_nxt;
    logic                accept;
    logic [DATA_W-1:0]   conv_res;
    logic [DATA_W-1:0]   lane [NUM_REQ];

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            lane[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Grants open in IDLE, and in DONE only on the cycle the result is consumed.
    assign arb_en  = (state_q == IDLE) || ((state_q == DONE) && res_ready);
    assign accept  = |arb_grant;
    assign ptr_nxt = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : arb_idx + ID_W'(1);

    fconv_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .valid_i (req_valid),
        .ptr_i   (rr_ptr_q),
        .en_i    (arb_en),
        .grant_o (arb_grant),
        .idx_o   (arb_idx)
    );

    if (DATA_W == FCONV_DW32) begin : g_cv32
        int2float32 u_cv (.op_i(op_q), .res_o(conv_res));
    end else if (DATA_W == FCONV_DW64) begin : g_cv64
        int2float64 u_cv (.op_i(op_q), .res_o(conv_res));
    end else begin : g_cv_bad
        $error("fconv_req_sched: DATA_W must be 32 or 64");
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_d        = op_q;
        id_d        = id_q;
        res_data_d  = res_data_q;
        res_id_d    = res_id_q;
        res_valid_d = res_valid_q;

        if (accept) begin
            op_d     = lane[arb_idx];
            id_d     = arb_idx;
            rr_ptr_d = ptr_nxt;
        end

        unique case (state_q)
            IDLE: begin
                if (accept) state_d = CONV;
            end
            CONV: begin
                res_data_d  = conv_res;
                res_id_d    = id_q;
                res_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = accept ? CONV : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_q        <= '0;
            id_q        <= '0;
            res_data_q  <= '0;
            res_id_q    <= '0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_q        <= op_d;
            id_q        <= id_d;
            res_data_q  <= res_data_d;
            res_id_q    <= res_id_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign req_ready = arb_grant;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_id    = res_id_q;
    assign busy      = (state_q != IDLE);

`ifdef FCONV_SCHED_PERF_EN
    logic [31:0] perf_conv_q;
    logic [31:0] perf_stall_q;

    // Free-running event counters; both wrap naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_conv_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (res_valid_q && res_ready)  perf_conv_q  <= perf_conv_q + 32'd1;
            if (res_valid_q && !res_ready) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_conv_cnt  = perf_conv_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule
